// File: rtl/sirv_tlul_reg_front.sv
// TileLink-UL slave front end: turns A-channel Get/Put into register requests and
// returns register responses (or locally generated errors) on the D channel, in order.
module sirv_tlul_reg_front #(
  parameter int INDEX_LSB = 2,
  parameter int INDEX_W   = 10,
  parameter int SRC_W     = 7,
  parameter int MAX_OUT   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [2:0]         a_opcode,
  input  logic [2:0]         a_size,
  input  logic [SRC_W-1:0]   a_source,
  input  logic [31:0]        a_address,
  input  logic [3:0]         a_mask,
  input  logic [31:0]        a_data,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_read,
  output logic [INDEX_W-1:0] req_index,
  output logic [31:0]        req_data,
  output logic [3:0]         req_mask,
  output logic [SRC_W+2:0]   req_extra,
  input  logic               rsp_valid,
  output logic               rsp_ready,
  input  logic               rsp_read,
  input  logic [31:0]        rsp_data,
  input  logic [SRC_W+2:0]   rsp_extra,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [2:0]         d_opcode,
  output logic [2:0]         d_size,
  output logic [SRC_W-1:0]   d_source,
  output logic [31:0]        d_data,
  output logic               d_error,
  output logic               idle
);

  localparam int OUT_W = 2;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

  logic [OUT_W-1:0] outstanding;
  logic             err_pend;
  logic [2:0]       err_opcode;
  logic [2:0]       err_size;
  logic [SRC_W-1:0] err_source;

  logic a_fire, a_legal, req_fire, rsp_fire, d_fire, err_drain;
  logic unused_addr;

  // Only the index field of the address is decoded; the rest is don't-care.
  assign unused_addr = ^a_address;

  assign a_ready  = !err_pend && (outstanding < OUT_MAX) && (!req_valid || req_ready);
  assign a_fire   = a_valid && a_ready;
  assign a_legal  = ((a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4)) &&
                    (a_size <= 3'd2);
  assign req_fire = req_valid && req_ready;
  assign rsp_ready = !d_valid || d_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign d_fire   = d_valid && d_ready;
  // The error may only leave once every older transaction has been answered.
  assign err_drain = err_pend && (outstanding == OUT_W'(1)) && rsp_ready && !rsp_fire;
  assign idle     = (outstanding == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_read  <= 1'b0;
      req_index <= '0;
      req_data  <= '0;
      req_mask  <= '0;
      req_extra <= '0;
    end else if (a_fire && a_legal) begin
      req_valid <= 1'b1;
      req_read  <= (a_opcode == 3'd4);
      req_index <= a_address[INDEX_LSB +: INDEX_W];
      req_data  <= a_data;
      req_mask  <= (a_opcode == 3'd4) ? 4'hF : a_mask;
      req_extra <= {a_source, a_size};
    end else if (req_fire) begin
      req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_pend   <= 1'b0;
      err_opcode <= '0;
      err_size   <= '0;
      err_source <= '0;
    end else if (a_fire && !a_legal) begin
      err_pend   <= 1'b1;
      err_source <= a_source;
      err_size   <= a_size;
      case (a_opcode)
        3'd2, 3'd3: err_opcode <= 3'd1;
        3'd5:       err_opcode <= 3'd2;
        default:    err_opcode <= 3'd0;
      endcase
    end else if (err_drain) begin
      err_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else if (rsp_fire) begin
      d_valid  <= 1'b1;
      d_opcode <= rsp_read ? 3'd1 : 3'd0;
      {d_source, d_size} <= rsp_extra;
      d_data   <= rsp_read ? rsp_data : 32'h0;
      d_error  <= 1'b0;
    end else if (err_drain) begin
      d_valid  <= 1'b1;
      d_opcode <= err_opcode;
      d_source <= err_source;
      d_size   <= err_size;
      d_data   <= 32'h0;
      d_error  <= 1'b1;
    end else if (d_fire) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (a_fire && !d_fire) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (d_fire && !a_fire) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  a_outstanding_underflow: assert property (@(posedge clock) disable iff (reset)
    !(d_fire && !a_fire && (outstanding == '0)));
  a_outstanding_overflow: assert property (@(posedge clock) disable iff (reset)
    !(a_fire && !d_fire && (outstanding == OUT_MAX)));

endmodule

// File: tb/tb_sirv_tlul_reg_front.sv
// Directed bench for sirv_tlul_reg_front: request decode, response return, error ordering,
// outstanding cap, D-channel backpressure and asynchronous reset.
module tb_sirv_tlul_reg_front;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_size = '0;
  logic [6:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_read;
  logic [9:0]  req_index;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic [9:0]  req_extra;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic        rsp_read = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [9:0]  rsp_extra = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [6:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic        idle;

  int checks = 0;
  int errors = 0;

  sirv_tlul_reg_front dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_index(req_index),
    .req_data(req_data), .req_mask(req_mask), .req_extra(req_extra),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read(rsp_read), .rsp_data(rsp_data),
    .rsp_extra(rsp_extra),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_error(d_error), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [6:0] src, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
    a_valid = 1'b1; a_opcode = op; a_size = 3'd2; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_valid !== 1'b0 || d_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_in: req_valid=%b d_valid=%b idle=%b want 0 0 1", req_valid, d_valid, idle);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1 || d_data !== 32'h0 || d_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: a_ready=%b d_data=%h d_error=%b want 1 0 0", a_ready, d_data, d_error);
    end
  endtask

  task automatic test_get();
    tick();
    drive_a(3'd4, 7'd5, 32'h10, 4'h0, 32'h0);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL get_aready: got %b want 1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_read !== 1'b1 || req_index !== 10'd4 || req_mask !== 4'hF ||
        req_extra !== 10'h2A || idle !== 1'b0) begin
      errors++;
      $display("FAIL get_req: v=%b rd=%b idx=%0d mask=%h extra=%h idle=%b want 1 1 4 f 02a 0",
               req_valid, req_read, req_index, req_mask, req_extra, idle);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0) begin
      errors++; $display("FAIL get_req_drop: req_valid=%b want 0", req_valid);
    end
    rsp_valid = 1'b1; rsp_read = 1'b1; rsp_data = 32'hDEADBEEF; rsp_extra = 10'h2A;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || d_opcode !== 3'd1 || d_source !== 7'd5 || d_size !== 3'd2 ||
        d_data !== 32'hDEADBEEF || d_error !== 1'b0) begin
      errors++;
      $display("FAIL get_d: v=%b op=%0d src=%0d size=%0d data=%h err=%b want 1 1 5 2 deadbeef 0",
               d_valid, d_opcode, d_source, d_size, d_data, d_error);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    checks++;
    if (d_valid !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL get_idle: d_valid=%b idle=%b want 0 1", d_valid, idle);
    end
  endtask

  task automatic test_put_partial();
    req_ready = 1'b1;
    drive_a(3'd1, 7'd3, 32'h8, 4'b0011, 32'h1234);
    tick();
    a_valid = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_read !== 1'b0 || req_index !== 10'd2 || req_mask !== 4'h3 ||
        req_data !== 32'h1234 || req_extra !== 10'h01A) begin
      errors++;
      $display("FAIL put_req: v=%b rd=%b idx=%0d mask=%h data=%h extra=%h want 1 0 2 3 1234 01a",
               req_valid, req_read, req_index, req_mask, req_data, req_extra);
    end
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_read = 1'b0; rsp_data = 32'hFFFF; rsp_extra = 10'h01A;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || d_opcode !== 3'd0 || d_data !== 32'h0 || d_source !== 7'd3) begin
      errors++;
      $display("FAIL put_d: v=%b op=%0d data=%h src=%0d want 1 0 0 3", d_valid, d_opcode, d_data, d_source);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
  endtask

  task automatic test_outstanding_cap();
    drive_a(3'd4, 7'd1, 32'h20, 4'h0, 32'h0);
    tick();
    drive_a(3'd4, 7'd2, 32'h24, 4'h0, 32'h0);
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL cap_stall: a_ready=%b want 0", a_ready);
    end
    tick();
    checks++;
    if (req_index !== 10'd8 || req_valid !== 1'b1) begin
      errors++; $display("FAIL cap_hold: idx=%0d v=%b want 8 1", req_index, req_valid);
    end
    req_ready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL cap_open: a_ready=%b want 1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    checks++;
    if (req_index !== 10'd9 || req_valid !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL cap_reload: idx=%0d v=%b a_ready=%b want 9 1 0", req_index, req_valid, a_ready);
    end
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_read = 1'b1; rsp_data = 32'h11; rsp_extra = {7'd1, 3'd2};
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (a_ready !== 1'b0 || req_valid !== 1'b0) begin
      errors++; $display("FAIL cap_full: a_ready=%b req_valid=%b want 0 0", a_ready, req_valid);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL cap_release: a_ready=%b want 1", a_ready);
    end
    rsp_valid = 1'b1; rsp_data = 32'h22; rsp_extra = {7'd2, 3'd2};
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (d_source !== 7'd2 || d_data !== 32'h22) begin
      errors++; $display("FAIL cap_second_d: src=%0d data=%h want 2 22", d_source, d_data);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
  endtask

  task automatic test_error_order();
    req_ready = 1'b1;
    drive_a(3'd4, 7'd3, 32'h0, 4'h0, 32'h0);
    tick();
    drive_a(3'd2, 7'd9, 32'h4, 4'hF, 32'h0);
    tick();
    a_valid = 1'b0;
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || a_ready !== 1'b0) begin
      errors++; $display("FAIL err_noreq: req_valid=%b a_ready=%b want 0 0", req_valid, a_ready);
    end
    tick();
    tick();
    checks++;
    if (d_valid !== 1'b0) begin
      errors++; $display("FAIL err_early: d_valid=%b want 0", d_valid);
    end
    rsp_valid = 1'b1; rsp_read = 1'b1; rsp_data = 32'h55; rsp_extra = {7'd3, 3'd2};
    tick();
    rsp_valid = 1'b0;
    tick();
    checks++;
    if (d_valid !== 1'b1 || d_error !== 1'b0 || d_source !== 7'd3 || d_data !== 32'h55) begin
      errors++;
      $display("FAIL err_get_first: v=%b err=%b src=%0d data=%h want 1 0 3 55", d_valid, d_error, d_source, d_data);
    end
    d_ready = 1'b1;
    tick();
    checks++;
    if (d_valid !== 1'b0) begin
      errors++; $display("FAIL err_gap: d_valid=%b want 0", d_valid);
    end
    tick();
    checks++;
    if (d_valid !== 1'b1 || d_error !== 1'b1 || d_opcode !== 3'd1 || d_source !== 7'd9 ||
        d_size !== 3'd2 || d_data !== 32'h0) begin
      errors++;
      $display("FAIL err_d: v=%b err=%b op=%0d src=%0d size=%0d data=%h want 1 1 1 9 2 0",
               d_valid, d_error, d_opcode, d_source, d_size, d_data);
    end
    tick();
    d_ready = 1'b0;
    checks++;
    if (d_valid !== 1'b0 || idle !== 1'b1 || a_ready !== 1'b1) begin
      errors++; $display("FAIL err_done: v=%b idle=%b a_ready=%b want 0 1 1", d_valid, idle, a_ready);
    end
  endtask

  task automatic test_d_backpressure();
    req_ready = 1'b1;
    drive_a(3'd4, 7'd1, 32'h0, 4'h0, 32'h0);
    tick();
    drive_a(3'd4, 7'd2, 32'h4, 4'h0, 32'h0);
    tick();
    a_valid = 1'b0;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_read = 1'b1; rsp_data = 32'hA0A0A0A0; rsp_extra = {7'd1, 3'd2};
    tick();
    rsp_data = 32'hB0B0B0B0; rsp_extra = {7'd2, 3'd2};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_ready !== 1'b0 || d_data !== 32'hA0A0A0A0 || d_source !== 7'd1 || d_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: rsp_ready=%b data=%h src=%0d v=%b want 0 a0a0a0a0 1 1",
                 i, rsp_ready, d_data, d_source, d_valid);
      end
      tick();
    end
    d_ready = 1'b1;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || d_data !== 32'hB0B0B0B0 || d_source !== 7'd2) begin
      errors++; $display("FAIL bp_next: v=%b data=%h src=%0d want 1 b0b0b0b0 2", d_valid, d_data, d_source);
    end
    tick();
    d_ready = 1'b0;
    checks++;
    if (d_valid !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL bp_done: v=%b idle=%b want 0 1", d_valid, idle);
    end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b1;
    drive_a(3'd4, 7'd4, 32'h40, 4'h0, 32'h0);
    tick();
    a_valid = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_read = 1'b1; rsp_data = 32'h77; rsp_extra = {7'd4, 3'd2};
    tick();
    rsp_valid = 1'b0;
    drive_a(3'd4, 7'd6, 32'h44, 4'h0, 32'h0);
    tick();
    a_valid = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || d_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre: req_valid=%b d_valid=%b want 1 1", req_valid, d_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_valid !== 1'b0 || d_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: req_valid=%b d_valid=%b idle=%b want 0 0 1", req_valid, d_valid, idle);
    end
    tick();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release: a_ready=%b want 1", a_ready);
    end
  endtask

  initial begin
    test_reset();
    test_get();
    test_put_partial();
    test_outstanding_cap();
    test_error_order();
    test_d_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
